// File: rtl/bus_pkg.sv
// Shared constants and helpers for the multi-master system bus.
package bus_pkg;

    localparam int NM_DEF = 2;
    localparam int NS_DEF = 4;
    localparam int AW_DEF = 16;
    localparam int DW_DEF = 64;
    localparam int RB_DEF = 11;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_OWNED = 1'b1
    } arb_state_e;

    // Index width for n items; never below 1 so single-entry vectors still get a select.
    function automatic int clog2(input int n);
        int r;
        r = 1;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    function automatic int unsigned region_idx(input logic [31:0] addr, input int rb);
        return addr >> rb;
    endfunction

endpackage

// File: rtl/multi_bus_if.sv
// Master-side and slave-side signal bundle of the shared bus.
interface multi_bus_if #(
    parameter int NM = 2,
    parameter int NS = 4,
    parameter int AW = 16,
    parameter int DW = 64
);
    logic [NM-1:0]          m_req;
    logic [NM-1:0]          m_wr;
    logic [NM-1:0][AW-1:0]  m_addr;
    logic [NM-1:0][DW-1:0]  m_dout;
    logic [NM-1:0]          m_grant;
    logic [DW-1:0]          m_din;
    logic                   m_err;
    logic [NS-1:0]          s_sel;
    logic                   s_wr;
    logic [AW-1:0]          s_addr;
    logic [DW-1:0]          s_din;
    logic [NS-1:0][DW-1:0]  s_dout;

    modport master (
        output m_req, m_wr, m_addr, m_dout,
        input  m_grant, m_din, m_err
    );

    modport slave (
        input  s_sel, s_wr, s_addr, s_din,
        output s_dout
    );

    modport fabric (
        input  m_req, m_wr, m_addr, m_dout, s_dout,
        output m_grant, m_din, m_err, s_sel, s_wr, s_addr, s_din
    );
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin bus-lock arbiter: the owner keeps the bus until it drops its request.
module rr_arbiter
    import bus_pkg::*;
#(
    parameter  int NM = NM_DEF,
    localparam int IW = clog2(NM)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [NM-1:0] req,
    output logic [NM-1:0] grant,
    output logic [IW-1:0] owner
);

    arb_state_e    state, nxt_state;
    logic [IW-1:0] last, nxt_last, nxt_owner, base, cand, pick;
    logic [NM-1:0] nxt_grant;
    logic          found;

    always_comb begin
        nxt_state = state;
        nxt_owner = owner;
        nxt_last  = last;
        base      = (state == ARB_OWNED) ? owner : last;
        found     = 1'b0;
        pick      = '0;
        cand      = '0;
        // Search starts one past base and wraps; base itself is visited last.
        for (int k = 1; k <= NM; k++) begin
            cand = IW'((int'(base) + k) % NM);
            if (!found && req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
        case (state)
            ARB_IDLE: begin
                if (found) begin
                    nxt_state = ARB_OWNED;
                    nxt_owner = pick;
                end
            end
            ARB_OWNED: begin
                if (!req[owner]) begin
                    nxt_last = owner;
                    if (found) nxt_owner = pick;
                    else       nxt_state = ARB_IDLE;
                end
            end
            default: nxt_state = ARB_IDLE;
        endcase
        nxt_grant = (nxt_state == ARB_OWNED) ? (NM'(1) << nxt_owner) : '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ARB_IDLE;
            last  <= IW'(NM - 1);
            owner <= '0;
            grant <= '0;
        end else begin
            state <= nxt_state;
            last  <= nxt_last;
            owner <= nxt_owner;
            grant <= nxt_grant;
        end
    end

endmodule

// File: rtl/multi_bus.sv
// Shared-bus interconnect: NM masters to NS address-decoded slaves with registered read return.
module multi_bus
    import bus_pkg::*;
#(
    parameter int NM = NM_DEF,
    parameter int NS = NS_DEF,
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF,
    parameter int RB = RB_DEF
) (
    input  logic        clk,
    input  logic        reset_n,
    multi_bus_if.fabric bus
);

    localparam int IW = clog2(NM);
    localparam int SW = clog2(NS);

    logic [NM-1:0] grant;
    logic [IW-1:0] owner;
    logic          act, mapped, rd_valid, err_q;
    int unsigned   idx;
    logic [SW-1:0] rd_idx;

    rr_arbiter #(.NM(NM)) u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (bus.m_req),
        .grant   (grant),
        .owner   (owner)
    );

    assign bus.m_grant = grant;
    assign bus.s_wr    = bus.m_wr[owner];
    assign bus.s_addr  = bus.m_addr[owner];
    assign bus.s_din   = bus.m_dout[owner];

    // A grant left over after the owner released its request issues no access.
    assign act    = (|grant) & bus.m_req[owner];
    assign idx    = region_idx(32'(bus.s_addr), RB);
    assign mapped = (idx < unsigned'(NS));

    always_comb begin
        bus.s_sel = '0;
        if (act && mapped) bus.s_sel[idx[SW-1:0]] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_valid <= 1'b0;
            rd_idx   <= '0;
            err_q    <= 1'b0;
        end else begin
            rd_valid <= act & ~bus.s_wr & mapped;
            rd_idx   <= idx[SW-1:0];
            err_q    <= act & ~mapped;
        end
    end

    assign bus.m_din = rd_valid ? bus.s_dout[rd_idx] : '0;
    assign bus.m_err = err_q;

endmodule
